evolved_gate_array: RTL and testbench

EVOLVED_GATE_ARRAY -- requirements
Module: evolved_gate_array

---
 rtl/evolved_gate_array_pkg.sv | 27 ++
 rtl/evolved_gate_array_cell.sv | 42 ++++
 rtl/evolved_gate_array.sv | 118 +++++++++++
 tb/tb_evolved_gate_array.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/evolved_gate_array_pkg.sv
// Shared types and encodings for the evolved gate array.
package evolved_gate_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } eg_state_e;

    // cfg word layout: {sel_a, sel_b, func[3:0]}
    localparam int FUNC_W   = 4;
    localparam int FUNC_LSB = 0;
    localparam int SELB_LSB = FUNC_W;

    // LUT index is {a, b}: a selects bit 1, b selects bit 0
    localparam int LUT_A_BIT = 1;
    localparam int LUT_B_BIT = 0;

    function automatic int sela_lsb(input int sel_w);
        return FUNC_W + sel_w;
    endfunction

    function automatic int cfg_w(input int sel_w);
        return 2 * sel_w + FUNC_W;
    endfunction

endpackage

// File: rtl/evolved_gate_array_cell.sv
// One registered 2-input LUT cell with its two source multiplexers.
module eg_cell
    import evolved_gate_array_pkg::*;
#(
    parameter int SRC   = 6,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [SRC-1:0]   src,
    input  logic [SEL_W-1:0] sel_a,
    input  logic [SEL_W-1:0] sel_b,
    input  logic [FUNC_W-1:0] func,
    output logic             nxt,
    output logic             q
);

    logic       a, b;
    logic [1:0] idx;

    // Source selection; indices past the source range read as 0
    always_comb begin
        a = 1'b0;
        b = 1'b0;
        if (32'(sel_a) < 32'(SRC)) a = src[sel_a];
        if (32'(sel_b) < 32'(SRC)) b = src[sel_b];
        idx            = '0;
        idx[LUT_A_BIT] = a;
        idx[LUT_B_BIT] = b;
        nxt            = func[idx];
    end

    // Output register: clear on start, update on each evaluation edge
    always_ff @(posedge clk) begin
        if (reset)    q <= 1'b0;
        else if (clr) q <= 1'b0;
        else if (en)  q <= nxt;
    end

endmodule

// File: rtl/evolved_gate_array.sv
// Array of registered LUT cells iterated until the outputs settle or a cycle budget runs out.
module evolved_gate_array
    import evolved_gate_array_pkg::*;
#(
    parameter int NUM_GATES     = 4,
    parameter int NUM_INPUTS    = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int MAX_CYCLES    = 64,
    parameter int OUT_GATE      = NUM_GATES - 1,
    localparam int SRC    = NUM_INPUTS + NUM_GATES,
    localparam int SEL_W  = $clog2(SRC),
    localparam int CFG_W  = cfg_w(SEL_W),
    localparam int ADDR_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] in,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [CFG_W-1:0]      cfg_data,
    input  logic                  start,
    input  logic                  keep_state,
    output logic                  busy,
    output logic                  done,
    output logic                  stable,
    output logic                  out,
    output logic [NUM_GATES-1:0]  cells
);

    localparam int EW    = $clog2(MAX_CYCLES + 1);
    localparam int SW    = $clog2(STABLE_CYCLES + 1);
    localparam int SA_LO = sela_lsb(SEL_W);

    eg_state_e                        state, state_d;
    logic [NUM_INPUTS-1:0]            in_q;
    logic [EW-1:0]                    edge_cnt, edge_inc;
    logic [SW-1:0]                    stb_cnt, stb_inc;
    logic [NUM_GATES-1:0][CFG_W-1:0]  cfg_q;
    logic [NUM_GATES-1:0]             cell_q, cell_nxt;
    logic [SRC-1:0]                   src;
    logic eval, start_acc, clr, unchanged, settle_hit, timeout_hit;
    logic done_q, stable_q;

    assign src         = {cell_q, in_q};
    assign eval        = (state == ST_SETTLE);
    assign start_acc   = start && !eval;
    assign clr         = start_acc && !keep_state;
    assign unchanged   = (cell_nxt == cell_q);
    assign stb_inc     = unchanged ? stb_cnt + 1'b1 : '0;
    assign edge_inc    = edge_cnt + 1'b1;
    assign settle_hit  = eval && (stb_inc == SW'(STABLE_CYCLES));
    assign timeout_hit = eval && (edge_inc == EW'(MAX_CYCLES));

    genvar g;
    generate
        for (g = 0; g < NUM_GATES; g++) begin : g_cell
            eg_cell #(.SRC(SRC), .SEL_W(SEL_W)) u_cell (
                .clk   (clk),
                .reset (reset),
                .clr   (clr),
                .en    (eval),
                .src   (src),
                .sel_a (cfg_q[g][SA_LO +: SEL_W]),
                .sel_b (cfg_q[g][SELB_LSB +: SEL_W]),
                .func  (cfg_q[g][FUNC_LSB +: FUNC_W]),
                .nxt   (cell_nxt[g]),
                .q     (cell_q[g])
            );
        end
    endgenerate

    // Next state: start leaves IDLE/DONE, settle or timeout leaves SETTLE
    always_comb begin
        state_d = state;
        if (start_acc)                         state_d = ST_SETTLE;
        else if (settle_hit || timeout_hit)    state_d = ST_DONE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Config store, input capture, counters and result flags
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q    <= '0;
            in_q     <= '0;
            edge_cnt <= '0;
            stb_cnt  <= '0;
            done_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            done_q <= settle_hit || timeout_hit;
            if (cfg_we && !eval && (32'(cfg_addr) < 32'(NUM_GATES)))
                cfg_q[cfg_addr] <= cfg_data;
            if (start_acc) begin
                in_q     <= in;
                edge_cnt <= '0;
                stb_cnt  <= '0;
                stable_q <= 1'b0;
            end else if (eval) begin
                edge_cnt <= edge_inc;
                stb_cnt  <= stb_inc;
                // settle wins over a coincident timeout
                if (settle_hit || timeout_hit) stable_q <= settle_hit;
            end
        end
    end

    assign busy   = eval;
    assign done   = done_q;
    assign stable = stable_q;
    assign out    = cell_q[OUT_GATE];
    assign cells  = cell_q;

endmodule

// File: tb/tb_evolved_gate_array.sv
// Directed self-checking bench for evolved_gate_array (default parameters).
module tb_evolved_gate_array;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] in = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [9:0] cfg_data = '0;
    logic       start = 1'b0;
    logic       keep_state = 1'b0;
    logic       busy, done, stable, out;
    logic [3:0] cells;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    evolved_gate_array dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .keep_state (keep_state),
        .busy       (busy),
        .done       (done),
        .stable     (stable),
        .out        (out),
        .cells      (cells)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic cfg_wr(input int addr, input int sa, input int sb, input int f);
        cfg_we   = 1'b1;
        cfg_addr = addr[1:0];
        cfg_data = {sa[2:0], sb[2:0], f[3:0]};
        tick;
        cfg_we   = 1'b0;
    endtask

    // NOR / OR / OR / AND network
    task automatic load_a;
        cfg_wr(0, 0, 1, 4'b0001);
        cfg_wr(1, 2, 1, 4'b1110);
        cfg_wr(2, 5, 0, 4'b1110);
        cfg_wr(3, 3, 4, 4'b1000);
    endtask

    // n = evaluation edges after the start edge at which done appears, -1 if never
    task automatic wait_done(input int pre, output int n);
        n = pre;
        for (int k = 0; k < 200 && !done; k++) begin
            tick;
            n++;
        end
        if (!done) n = -1;
    endtask

    task automatic run(input logic [1:0] iv, input logic kp, output int n);
        in = iv;
        keep_state = kp;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(0, n);
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (stable !== 1'b0)  begin failures++; $display("FAIL reset_stable got=%b exp=0", stable); end
        checks++; if (out !== 1'b0)     begin failures++; $display("FAIL reset_out got=%b exp=0", out); end
        checks++; if (cells !== 4'b0000) begin failures++; $display("FAIL reset_cells got=%b exp=0000", cells); end
    endtask

    task automatic test_settle;
        int n;
        load_a;
        run(2'b00, 1'b0, n);
        checks++; if (n != 4)            begin failures++; $display("FAIL settle_edges got=%0d exp=4", n); end
        checks++; if (stable !== 1'b1)   begin failures++; $display("FAIL settle_stable got=%b exp=1", stable); end
        checks++; if (out !== 1'b0)      begin failures++; $display("FAIL settle_out got=%b exp=0", out); end
        checks++; if (cells !== 4'b0011) begin failures++; $display("FAIL settle_cells got=%b exp=0011", cells); end
        tick;
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL done_pulse got=%b exp=0", done); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL done_busy got=%b exp=0", busy); end
        checks++; if (cells !== 4'b0011) begin failures++; $display("FAIL done_hold got=%b exp=0011", cells); end
    endtask

    task automatic test_keep_state;
        int n;
        run(2'b11, 1'b0, n);
        checks++; if (n != 4)            begin failures++; $display("FAIL in11_edges got=%0d exp=4", n); end
        checks++; if (out !== 1'b1)      begin failures++; $display("FAIL in11_out got=%b exp=1", out); end
        checks++; if (cells !== 4'b1110) begin failures++; $display("FAIL in11_cells got=%b exp=1110", cells); end
        // retained state is already a fixed point: settles after two unchanged edges
        run(2'b11, 1'b1, n);
        checks++; if (n != 2)            begin failures++; $display("FAIL keep11_edges got=%0d exp=2", n); end
        checks++; if (stable !== 1'b1)   begin failures++; $display("FAIL keep11_stable got=%b exp=1", stable); end
        checks++; if (cells !== 4'b1110) begin failures++; $display("FAIL keep11_cells got=%b exp=1110", cells); end
        // from 1110 with in=00 the cell2/cell3 loop alternates 0111/1011 forever
        run(2'b00, 1'b1, n);
        checks++; if (n != 64)           begin failures++; $display("FAIL keep00_edges got=%0d exp=64", n); end
        checks++; if (stable !== 1'b0)   begin failures++; $display("FAIL keep00_stable got=%b exp=0", stable); end
        checks++; if (cells !== 4'b0111) begin failures++; $display("FAIL keep00_cells got=%b exp=0111", cells); end
    endtask

    task automatic test_oscillate;
        int k;
        do_reset;
        cfg_wr(0, 2, 2, 4'b0011);
        in = 2'b00;
        keep_state = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (k = 1; k <= 64; k++) begin
            tick;
            checks++;
            if (cells[0] !== k[0]) begin
                failures++;
                $display("FAIL osc_toggle edge=%0d got=%b exp=%b", k, cells[0], k[0]);
            end
        end
        checks++; if (done !== 1'b1)     begin failures++; $display("FAIL osc_done got=%b exp=1", done); end
        checks++; if (stable !== 1'b0)   begin failures++; $display("FAIL osc_stable got=%b exp=0", stable); end
        checks++; if (cells !== 4'b0000) begin failures++; $display("FAIL osc_cells got=%b exp=0000", cells); end
    endtask

    task automatic test_busy_ignore;
        int n;
        do_reset;
        load_a;
        in = 2'b00;
        keep_state = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy); end
        cfg_we   = 1'b1;
        cfg_addr = 2'd3;
        cfg_data = {3'd0, 3'd0, 4'b1111};
        start    = 1'b1;
        in       = 2'b11;
        tick;
        cfg_we = 1'b0;
        start  = 1'b0;
        in     = 2'b00;
        wait_done(2, n);
        checks++; if (n != 4)            begin failures++; $display("FAIL ign_edges got=%0d exp=4", n); end
        checks++; if (cells !== 4'b0011) begin failures++; $display("FAIL ign_cells got=%b exp=0011", cells); end
        run(2'b00, 1'b0, n);
        checks++; if (n != 4)            begin failures++; $display("FAIL ign_rerun_edges got=%0d exp=4", n); end
        checks++; if (cells !== 4'b0011) begin failures++; $display("FAIL ign_rerun_cells got=%b exp=0011", cells); end
    endtask

    task automatic test_cfg_with_start;
        int n;
        do_reset;
        cfg_wr(0, 0, 1, 4'b0001);
        cfg_wr(1, 2, 1, 4'b1110);
        cfg_wr(2, 5, 0, 4'b1110);
        cfg_wr(3, 3, 4, 4'b0000);
        cfg_we     = 1'b1;
        cfg_addr   = 2'd3;
        cfg_data   = {3'd3, 3'd4, 4'b1000};
        in         = 2'b11;
        keep_state = 1'b0;
        start      = 1'b1;
        tick;
        cfg_we = 1'b0;
        start  = 1'b0;
        wait_done(0, n);
        checks++; if (n != 4)            begin failures++; $display("FAIL cfgstart_edges got=%0d exp=4", n); end
        checks++; if (cells !== 4'b1110) begin failures++; $display("FAIL cfgstart_cells got=%b exp=1110", cells); end
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset;
        cfg_wr(0, 2, 2, 4'b0011);
        in = 2'b00;
        keep_state = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL rmid_done got=%b exp=0", done); end
        checks++; if (cells !== 4'b0000) begin failures++; $display("FAIL rmid_cells got=%b exp=0000", cells); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmid_nodone cyc=%0d got=%b exp=0", k, done); end
        end
        run(2'b00, 1'b1, n);
        checks++; if (n != 2)            begin failures++; $display("FAIL rmid_rerun_edges got=%0d exp=2", n); end
        checks++; if (stable !== 1'b1)   begin failures++; $display("FAIL rmid_stable got=%b exp=1", stable); end
        checks++; if (cells !== 4'b0000) begin failures++; $display("FAIL rmid_rerun_cells got=%b exp=0000", cells); end
    endtask

    task automatic test_out_of_range;
        int n;
        do_reset;
        cfg_wr(0, 7, 0, 4'b1100);
        cfg_wr(1, 7, 7, 4'b0001);
        run(2'b11, 1'b0, n);
        checks++; if (n != 3)            begin failures++; $display("FAIL oor_edges got=%0d exp=3", n); end
        checks++; if (stable !== 1'b1)   begin failures++; $display("FAIL oor_stable got=%b exp=1", stable); end
        checks++; if (cells !== 4'b0010) begin failures++; $display("FAIL oor_cells got=%b exp=0010", cells); end
    endtask

    initial begin
        test_reset;
        test_settle;
        test_keep_state;
        test_oscillate;
        test_busy_ignore;
        test_cfg_with_start;
        test_reset_mid;
        test_out_of_range;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
